// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline stall/flush controller that resolves load-use hazards,
//            data-memory waits and taken-branch flushes.
// Option   : HAZARD_PERF_CNT_EN adds a saturating stall_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_Rn,
  input  logic [4:0] id_Rm,
  input  logic       id_uses_Rn,
  input  logic       id_uses_Rm,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_Rd,
  input  logic       br_taken,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [1:0] S_RUN      = 2'b00;
  localparam logic [1:0] S_LU_STALL = 2'b01;
  localparam logic [1:0] S_MEM_WAIT = 2'b10;
  localparam logic [1:0] S_FLUSH    = 2'b11;

  logic [1:0] state_q, state_d;
  logic [4:0] ctrl_en;   // {pc, ifid, idex, exmem, memwb}
  logic [2:0] ctrl_fl;   // {ifid, idex, exmem}
  logic       memwait;
  logic       load_use;

  assign memwait  = mem_req & ~mem_ack;
  // XZR is hard-wired zero, so a load targeting it can never feed a consumer.
  assign load_use = ex_MemRead & (ex_Rd != 5'd31) &
                    ((id_uses_Rn & (id_Rn == ex_Rd)) |
                     (id_uses_Rm & (id_Rm == ex_Rd)));

  always_comb begin
    state_d = S_RUN;
    ctrl_en = 5'b11111;
    ctrl_fl = 3'b000;
    case (state_q)
      S_RUN: begin
        if (memwait) begin
          ctrl_en = 5'b00000;
          state_d = S_MEM_WAIT;
        end else if (br_taken) begin
          ctrl_fl = 3'b111;
          state_d = S_FLUSH;
        end else if (load_use) begin
          ctrl_en = 5'b00111;
          ctrl_fl = 3'b010;
          state_d = S_LU_STALL;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_ack) begin
          ctrl_en = 5'b00000;
          state_d = S_MEM_WAIT;
        end
      end
      default: begin
        // One-cycle shadow after a bubble: only a memory wait matters here.
        if (memwait) begin
          ctrl_en = 5'b00000;
          state_d = S_MEM_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  assign state       = state_q;
  assign pc_en       = ~rst & ctrl_en[4];
  assign ifid_en     = ~rst & ctrl_en[3];
  assign idex_en     = ~rst & ctrl_en[2];
  assign exmem_en    = ~rst & ctrl_en[1];
  assign memwb_en    = ~rst & ctrl_en[0];
  assign ifid_flush  = rst | ctrl_fl[2];
  assign idex_flush  = rst | ctrl_fl[1];
  assign exmem_flush = rst | ctrl_fl[0];

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_en && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= 32'd0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed plus randomized self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_Rn = '0, id_Rm = '0, ex_Rd = '0;
  logic       id_uses_Rn = 1'b0, id_uses_Rm = 1'b0, ex_MemRead = 1'b0;
  logic       br_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_Rn(id_Rn), .id_Rm(id_Rm), .id_uses_Rn(id_uses_Rn), .id_uses_Rm(id_uses_Rm),
    .ex_MemRead(ex_MemRead), .ex_Rd(ex_Rd), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .state(state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl}
  logic [7:0] outs;
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush};

  localparam logic [7:0] NORM = 8'b11111_000;
  localparam logic [7:0] OFF  = 8'b00000_000;
  localparam logic [7:0] BRF  = 8'b11111_111;
  localparam logic [7:0] LUV  = 8'b00111_010;
  localparam logic [7:0] RSTV = 8'b00000_111;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: "inside a memory wait" and "previous cycle inserted a bubble".
  bit          m_wait = 0;
  bit          m_bubble = 0;
  logic [1:0]  m_bubble_state = 2'd0;
  longint      m_cnt = 0;

  always @(negedge clk) begin
    logic [7:0] e_out;
    logic [1:0] e_st;
    bit mw, lu;
    if (rst) begin
      e_out = RSTV; e_st = 2'd0;
      m_wait = 0; m_bubble = 0; m_cnt = 0;
    end else begin
      mw = mem_req && !mem_ack;
      lu = ex_MemRead && (ex_Rd != 5'd31) &&
           ((id_uses_Rn && id_Rn == ex_Rd) || (id_uses_Rm && id_Rm == ex_Rd));
      e_st = m_wait ? 2'd2 : (m_bubble ? m_bubble_state : 2'd0);
      if (m_wait) begin
        e_out = mem_ack ? NORM : OFF;
        m_wait = !mem_ack;
      end else if (mw) begin
        e_out = OFF; m_wait = 1; m_bubble = 0;
      end else if (m_bubble) begin
        e_out = NORM; m_bubble = 0;
      end else if (br_taken) begin
        e_out = BRF; m_bubble = 1; m_bubble_state = 2'd3;
      end else if (lu) begin
        e_out = LUV; m_bubble = 1; m_bubble_state = 2'd1;
      end else begin
        e_out = NORM;
      end
    end
    n_cmp++;
    if (outs !== e_out || state !== e_st) begin
      n_bad++;
      $display("FAIL model @%0t: got state=%0d outs=%b, expected state=%0d outs=%b",
               $time, state, outs, e_st, e_out);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++;
    if (stall_cycles !== m_cnt[31:0]) begin
      n_bad++;
      $display("FAIL stall_cycles @%0t: got %0d, expected %0d", $time, stall_cycles, m_cnt);
    end
    if (!rst && e_out[7] == 1'b0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
`endif
  end

  task automatic drv(input logic [4:0] rn, rm, input logic urn, urm, mr,
                     input logic [4:0] rd, input logic br, req, ack);
    @(posedge clk); #1;
    id_Rn = rn; id_Rm = rm; id_uses_Rn = urn; id_uses_Rm = urm;
    ex_MemRead = mr; ex_Rd = rd; br_taken = br; mem_req = req; mem_ack = ack;
    #1;
  endtask

  task automatic idle();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic dchk(input string nm, input logic [1:0] es, input logic [7:0] ev);
    n_cmp++;
    if (outs !== ev || state !== es) begin
      n_bad++;
      $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
               nm, state, outs, es, ev);
    end
  endtask

  initial begin
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] c0;
`endif
    #3 dchk("reset_outputs", 2'd0, RSTV);
    @(posedge clk); #1 rst = 1'b0;
    #1 dchk("first_run", 2'd0, NORM);

    // load-use on Rn, hazard still visible during the stall cycle
    drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); dchk("lu_detect", 2'd0, LUV);
    drv(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); dchk("lu_state", 2'd1, NORM);
    idle(); dchk("lu_return", 2'd0, NORM);

    drv(5'd31, 5'd0, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0); dchk("xzr", 2'd0, NORM);
    drv(5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); dchk("rm_unused", 2'd0, NORM);

    // memory wait of three cycles
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    c0 = stall_cycles;
`endif
    dchk("mw_1", 2'd0, OFF);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); dchk("mw_2", 2'd2, OFF);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); dchk("mw_3", 2'd2, OFF);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); dchk("mw_ack", 2'd2, NORM);
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++;
    if (stall_cycles !== c0 + 32'd3) begin
      n_bad++;
      $display("FAIL mw_count: got %0d, expected %0d", stall_cycles, c0 + 32'd3);
    end
`endif
    idle(); dchk("mw_return", 2'd0, NORM);

    // branch, then branch + load-use in the shadow cycle are ignored
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); dchk("br", 2'd0, BRF);
    drv(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); dchk("br_shadow", 2'd3, NORM);
    idle(); dchk("br_return", 2'd0, NORM);

    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); dchk("mw_beats_br", 2'd0, OFF);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); dchk("mw_br_ack", 2'd2, NORM);
    drv(5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); dchk("br_beats_lu", 2'd0, BRF);
    idle(); dchk("br_lu_shadow", 2'd3, NORM);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); dchk("ack_no_req", 2'd0, NORM);

    // asynchronous reset during MEM_WAIT
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); dchk("rst_mw1", 2'd0, OFF);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); dchk("rst_mw2", 2'd2, OFF);
    #1 rst = 1'b1;
    #1 dchk("rst_async", 2'd0, RSTV);
    @(posedge clk); #1 rst = 1'b0;
    mem_req = 1'b0;
    #1 dchk("rst_release", 2'd0, NORM);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 99) == 0);
      id_Rn      = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      id_Rm      = 5'($urandom_range(0, 3));
      ex_Rd      = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      id_uses_Rn = 1'($urandom_range(0, 1));
      id_uses_Rm = 1'($urandom_range(0, 1));
      ex_MemRead = 1'($urandom_range(0, 1));
      br_taken   = ($urandom_range(0, 5) == 0);
      mem_req    = ($urandom_range(0, 3) == 0);
      mem_ack    = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have inputs id_Rn and id_Rm, 5 bits each: source register numbers of the instruction in ID.
REQ-004 SHALL have inputs id_uses_Rn and id_uses_Rm, 1 bit each: the ID instruction actually reads that source.
REQ-005 SHALL have inputs ex_MemRead (1 bit) and ex_Rd (5 bits): the load flag and destination register from the ID/EX register outputs.
REQ-006 SHALL have input br_taken, 1 bit: a taken branch is resolved in the MEM stage this cycle.
REQ-007 SHALL have inputs mem_req and mem_ack, 1 bit each: MEM-stage data-memory access pending, and access completes this cycle.
REQ-008 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en and memwb_en, 1 bit each: per-stage register enables.
REQ-009 SHALL have outputs ifid_flush, idex_flush and exmem_flush, 1 bit each: load a bubble (all controls 0) into that register.
REQ-010 SHALL have output state, 2 bits: current FSM state.

Function
REQ-011 SHALL implement states RUN=00, LU_STALL=01, MEM_WAIT=10 and FLUSH=11; outputs are combinational from the state and inputs, and the state is registered.
REQ-012 SHALL detect load-use when ex_MemRead=1, ex_Rd!=31, and either (id_uses_Rn and id_Rn==ex_Rd) or (id_uses_Rm and id_Rm==ex_Rd); register 31 (XZR) never hazards.
REQ-013 SHALL treat memwait as mem_req=1 and mem_ack=0.
REQ-014 SHALL apply this priority in RUN: memwait, then br_taken, then load-use, then normal operation.
REQ-015 SHALL, in RUN on memwait: drive all enables 0 and all flushes 0; next state MEM_WAIT.
REQ-016 SHALL, in RUN on br_taken: drive all enables 1 and ifid/idex/exmem_flush 1; next state FLUSH.
REQ-017 SHALL, in RUN on load-use: drive pc_en=0 and ifid_en=0, with idex_en=1, idex_flush=1, and exmem_en=memwb_en=1; next state LU_STALL.
REQ-018 SHALL, in RUN with no event, or in LU_STALL or FLUSH without memwait: drive all enables 1 and all flushes 0; next state RUN.
REQ-019 SHALL suppress load-use detection and ignore br_taken in LU_STALL and FLUSH.
REQ-020 SHALL, on memwait in LU_STALL or FLUSH, behave as REQ-015.
REQ-021 SHALL, in MEM_WAIT with mem_ack=0, hold all enables 0 and ignore other inputs.
REQ-022 SHALL, in MEM_WAIT with mem_ack=1, drive all enables 1 and return to RUN; hazards are evaluated again from that next cycle.
REQ-023 SHALL never assert a flush together with a 0 enable on the same register.
REQ-024 SHALL treat mem_ack=1 while mem_req=0 as a no-op.

Reset
REQ-025 SHALL, while rst=1, force state to RUN, all enables to 0 and all flushes to 1, asynchronously.
REQ-026 SHALL, on the first clk edge after rst deasserts, operate from RUN, with no extra cycle.
REQ-027 SHALL, when rst asserts mid-stall (any state), abandon the stall immediately; there is no memory of a pending hazard.

Configuration
REQ-028 SHALL, when macro HAZARD_PERF_CNT_EN is defined, add output stall_cycles (32 bits).
REQ-029 SHALL increment stall_cycles on every clk edge where pc_en=0 and rst=0, saturate at 0xFFFFFFFF, and reset to 0.
REQ-030 SHALL, when HAZARD_PERF_CNT_EN is undefined, omit the port and counter entirely, with identical remaining behaviour.

Verification
REQ-031 SHALL test load-use: ex_MemRead=1, ex_Rd=5, id_Rn=5, id_uses_Rn=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, state 01, then RUN.
REQ-032 SHALL test XZR/unused: ex_Rd=31 with id_Rn=31; then ex_Rd=5, id_Rm=5, id_uses_Rm=0 -> no stall, enables 1.
REQ-033 SHALL test memwait: mem_req=1 with mem_ack low for 3 cycles, then high -> 3 cycles with all enables 0 (state 10), an ack cycle with enables 1, then RUN; stall_cycles=+3 when enabled.
REQ-034 SHALL test branch: br_taken=1 -> the three flushes 1 for one cycle, state 11; a br_taken or load-use in the FLUSH cycle is ignored.
REQ-035 SHALL test simultaneous events: memwait+br_taken -> MEM_WAIT, branch ignored; br_taken+load-use -> FLUSH, no stall.
REQ-036 SHALL test reset: assert rst during MEM_WAIT -> state 00 and enables 0 without a clock edge; after release, normal RUN on the next edge.
